alu_op_sequencer: RTL and testbench

//  Upstream issue stage for the combinational alu. Buffers operation requests {op,n1,n2}
//  in a DEPTH-entry FIFO with a valid/ready handshake, drives the FIFO head onto the alu

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request and result handshake bundle between the alu_op_sequencer and its producer/consumer.
// master = producer of requests / consumer of results; slave = the sequencer.
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_n1;
  logic [31:0] cmd_n2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic        res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_n1, cmd_n2, res_ready,
    input  cmd_ready, res_valid, res_data, res_op, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_n1, cmd_n2, res_ready,
    output cmd_ready, res_valid, res_data, res_op, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// FIFO-buffered issue stage for a combinational alu, with a registered result slot.
// Optional macro ALU_DIVZERO_CHECK_EN: divide-by-zero yields all-ones data and res_err=1.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [31:0]       alu_n1,
  output logic [31:0]       alu_n2,
  output logic [1:0]        alu_op,
  input  logic [31:0]       alu_res,
  output logic [AW:0]       level
);
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_HELD = 1'b1} slot_e;

  logic [1:0]    op_mem_q [DEPTH];
  logic [31:0]   n1_mem_q [DEPTH];
  logic [31:0]   n2_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  slot_e         slot_q;
  logic [31:0]   res_data_q, res_data_d;
  logic [1:0]    res_op_q, res_op_d;
  logic          res_err_q, res_err_d;
  logic          empty_s, full_s, push_s, pop_s, divz_s, res_valid_s;

  // Full/empty derive only from the occupancy counter; ready never depends on pop.
  assign empty_s     = (level_q == {(AW+1){1'b0}});
  assign full_s      = (level_q == (AW+1)'(DEPTH));
  assign res_valid_s = (slot_q == SLOT_HELD);
  assign push_s      = bus.cmd_valid & ~full_s;
  assign pop_s       = ~empty_s & (~res_valid_s | bus.res_ready);

`ifdef ALU_DIVZERO_CHECK_EN
  assign divz_s = (op_mem_q[rd_ptr_q] == 2'b11) && (n2_mem_q[rd_ptr_q] == 32'd0);
`else
  assign divz_s = 1'b0;
`endif

  // Present the FIFO head to the alu, forced to zero while empty
  always_comb begin
    alu_op = 2'b00;
    alu_n1 = 32'd0;
    alu_n2 = 32'd0;
    if (!empty_s) begin
      alu_op = op_mem_q[rd_ptr_q];
      alu_n1 = n1_mem_q[rd_ptr_q];
      alu_n2 = n2_mem_q[rd_ptr_q];
    end else begin
      alu_op = 2'b00;
      alu_n1 = 32'd0;
      alu_n2 = 32'd0;
    end
  end

  // Next-state for pointers, occupancy and result payload
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    res_err_d  = res_err_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      res_data_d = divz_s ? 32'hFFFF_FFFF : alu_res;
      res_op_d   = op_mem_q[rd_ptr_q];
      res_err_d  = divz_s;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      res_data_d = res_data_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers, FIFO storage and the result-slot state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {(AW+1){1'b0}};
      slot_q     <= SLOT_EMPTY;
      res_data_q <= 32'd0;
      res_op_q   <= 2'b00;
      res_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      res_err_q  <= res_err_d;
      if (push_s) begin
        op_mem_q[wr_ptr_q] <= bus.cmd_op;
        n1_mem_q[wr_ptr_q] <= bus.cmd_n1;
        n2_mem_q[wr_ptr_q] <= bus.cmd_n2;
      end
      case (slot_q)
        SLOT_EMPTY: begin
          if (pop_s) slot_q <= SLOT_HELD;
          else       slot_q <= SLOT_EMPTY;
        end
        SLOT_HELD: begin
          if (bus.res_ready && !pop_s) slot_q <= SLOT_EMPTY;
          else                         slot_q <= SLOT_HELD;
        end
        default: slot_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign bus.cmd_ready = ~full_s;
  assign bus.res_valid = res_valid_s;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_err   = res_err_q;
  assign level         = level_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural alu closes the loop, a queue-based
// model tracks FIFO contents and the result slot, and a negedge monitor compares outputs.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_n1, alu_n2, alu_res;
  logic [1:0]  alu_op;
  logic [2:0]  level;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_op(alu_op),
    .alu_res(alu_res), .level(level)
  );

  // Behavioural alu; division by zero returns 0 so the divide-by-zero override is visible
  function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == 32'd0) ? 32'd0 : a / b;
    endcase
  endfunction

  always_comb alu_res = alu_fn(alu_op, alu_n1, alu_n2);

  typedef struct packed {logic [1:0] op; logic [31:0] n1; logic [31:0] n2;} cmd_t;
  typedef struct packed {logic [31:0] data; logic [1:0] op; logic err;} res_t;

  cmd_t fq[$];
  res_t exp_q[$];
  bit   mslot;
  bit   mon_en;
  bit   rnd_en;
  int   checks;
  int   passes;

  function automatic res_t exp_of(input cmd_t c);
    res_t r;
    r.op   = c.op;
    r.err  = 1'b0;
    r.data = alu_fn(c.op, c.n1, c.n2);
`ifdef ALU_DIVZERO_CHECK_EN
    if (c.op == 2'b11 && c.n2 == 32'd0) begin
      r.data = 32'hFFFF_FFFF;
      r.err  = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: compare against the model, then advance the model by what the next edge does
  always @(negedge clk) begin
    if (mon_en) begin
      cmd_t h;
      cmd_t c;
      res_t e;
      bit   push, pop, take;
      h = (fq.size() > 0) ? fq[0] : '0;
      chk("level", 32'(level), 32'(fq.size()));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(fq.size() < DEPTH));
      chk("res_valid", 32'(bus.res_valid), 32'(mslot));
      chk("alu_op", 32'(alu_op), 32'(h.op));
      chk("alu_n1", alu_n1, h.n1);
      chk("alu_n2", alu_n2, h.n2);
      if (!rst_n) begin
        fq.delete();
        exp_q.delete();
        mslot = 1'b0;
      end else begin
        push = bus.cmd_valid && (fq.size() < DEPTH);
        take = mslot && bus.res_ready;
        pop  = (fq.size() > 0) && (!mslot || bus.res_ready);
        if (take) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", bus.res_data, e.data);
            chk("res_op", 32'(bus.res_op), 32'(e.op));
            chk("res_err", 32'(bus.res_err), 32'(e.err));
          end
        end
        if (pop) void'(fq.pop_front());
        if (push) begin
          c.op = bus.cmd_op;
          c.n1 = bus.cmd_n1;
          c.n2 = bus.cmd_n2;
          fq.push_back(c);
          exp_q.push_back(exp_of(c));
        end
        if (pop) mslot = 1'b1;
        else if (take) mslot = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_en) bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_n1    = a;
    bus.cmd_n2    = b;
    @(negedge clk);
    while (!bus.cmd_ready && w < 100) begin
      step();
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_n1    = 32'd0;
    bus.cmd_n2    = 32'd0;
    bus.res_ready = 1'b0;
    rst_n  = 1'b0;
    rnd_en = 1'b0;
    checks = 0;
    passes = 0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_op", 32'(bus.res_op), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);

    // Single ops with the consumer always ready
    bus.res_ready = 1'b1;
    step();
    send(2'b00, 32'd17, 32'd21);
    send(2'b01, 32'd55, 32'd40);
    send(2'b10, 32'd7, 32'd12);
    send(2'b11, 32'd14, 32'd3);
    idle(4);

    // Backpressure: fill the FIFO behind a held result
    bus.res_ready = 1'b0;
    send(2'b00, 32'd17, 32'd21);
    send(2'b01, 32'd55, 32'd40);
    send(2'b10, 32'd7, 32'd12);
    send(2'b11, 32'd14, 32'd3);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_level_after4", 32'(level), 32'd3);
    step();
    send(2'b11, 32'd999, 32'd9);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_level_full", 32'(level), 32'd4);
    chk("bp_ready_full", 32'(bus.cmd_ready), 32'd0);
    step();
    bus.res_ready = 1'b1;
    idle(8);

    // Streaming: cmd_valid and res_ready held high
    for (int i = 0; i < 6; i++) send(2'b00, 32'(i * 3), 32'(i));
    send(2'b10, 32'd77, 32'd11);
    send(2'b01, 32'd5, 32'd9);
    idle(4);

    // Reset with queued work and a held result
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b10, 32'(i + 2), 32'd5);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("prerst_level", 32'(level), 32'd3);
    chk("prerst_valid", 32'(bus.res_valid), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_level", 32'(level), 32'd0);
    chk("postrst_valid", 32'(bus.res_valid), 32'd0);
    chk("postrst_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.res_ready = 1'b1;
    send(2'b00, 32'd100, 32'd23);
    idle(4);

    // Divide by zero
    send(2'b11, 32'd9, 32'd0);
    idle(3);

    // Pointer wrap
    for (int i = 0; i < 2 * DEPTH + 1; i++) send(2'b00, 32'(i), 32'd1);
    idle(4);

    // Random traffic with random consumer backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      send(op, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_en = 1'b0;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
